// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : word-addressed SRAM responder with programmable wait states,
//                  MEM-stage stall generation and illegal-access flagging.
// Revision       : 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MR,
  input  logic        MW,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Stall,
  output logic        AddrError
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        aerr_q, aerr_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             in_idle;
  logic             sel_rd, sel_wr;
  logic [31:0]      sel_addr, sel_wdata;
  logic [IDX_W-1:0] sel_idx;
  logic             illegal, enter_resp, mem_we;

  always_comb begin
    // With zero wait states the commit happens on the accepting edge, so the
    // live request must be used instead of the not-yet-latched copy.
    in_idle   = (state_q == ST_IDLE);
    sel_rd    = in_idle ? MR        : rd_q;
    sel_wr    = in_idle ? MW        : wr_q;
    sel_addr  = in_idle ? Address   : addr_q;
    sel_wdata = in_idle ? WriteData : wdata_q;
    sel_idx   = sel_addr[IDX_W+1:2];
    illegal   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= DEPTH_LIM) || (sel_rd && sel_wr);

    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    aerr_d     = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (MR || MW) begin
          rd_d    = MR;
          wr_d    = MW;
          addr_d  = Address;
          wdata_d = WriteData;
          if (WAIT_STATES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      ready_d = 1'b1;
      aerr_d  = illegal;
      if (illegal)     rdata_d = 32'd0;
      else if (sel_rd) rdata_d = mem[sel_idx];
    end

    mem_we = enter_resp && reset && !illegal && sel_wr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      aerr_q  <= aerr_d;
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[sel_idx] <= sel_wdata;
  end

  assign ReadData  = rdata_q;
  assign Ready     = ready_q;
  assign AddrError = aerr_q;
  assign Stall     = (state_q == ST_IDLE && (MR || MW)) || (state_q == ST_WAIT);

endmodule
`default_nettype wire
